// File: rtl/m_key_press.sv
// Push-button front end: synchronizes, debounces and classifies each key into press, long-hold and short-release events.
// Optional auto-repeat of key_first while a key is held long is enabled by defining KEY_REPEAT_EN.
module m_key_press #(
    parameter int unsigned N_KEYS         = 2,
    parameter int unsigned IN_CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS    = 20,
    parameter int unsigned LONG_MS        = 1000,
    parameter int unsigned REPEAT_MS      = 200,
    parameter int unsigned KEY_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_first,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_short,
    output logic [N_KEYS-1:0] key_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_e;

    localparam int unsigned DEB_CYC  = IN_CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_CYC = IN_CLK_HZ / 1000 * LONG_MS;
`ifdef KEY_REPEAT_EN
    localparam int unsigned REPEAT_CYC = IN_CLK_HZ / 1000 * REPEAT_MS;
`endif
    localparam logic [N_KEYS-1:0] INV_MASK = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

    // Reject parameter sets that would make a counter terminal value underflow.
    if (IN_CLK_HZ < 1000 || DEBOUNCE_MS == 0 || LONG_MS == 0 || REPEAT_MS == 0 || KEY_ACTIVE_LOW > 1)
    begin : g_bad_cfg
        $error("m_key_press: invalid parameter set");
    end

    // Polarity is normalized ahead of the synchronizer so reset (all 0) reads as released.
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = key_in ^ INV_MASK;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic        key_s;
        logic        key_db_q, key_db_d;
        logic [31:0] deb_cnt_q, deb_cnt_d;
        state_e      state_q, state_d;
        logic [31:0] hold_cnt_q, hold_cnt_d;
        logic        first_q, first_d;
        logic        short_q, short_d;
        logic        long_q, long_d;
`ifdef KEY_REPEAT_EN
        logic [31:0] rep_cnt_q, rep_cnt_d;
`endif

        assign key_s = sync2_q[k];

        // Accept a new level only after it has been seen for DEB_CYC consecutive cycles.
        always_comb begin
            key_db_d  = key_db_q;
            deb_cnt_d = '0;
            if (key_s != key_db_q) begin
                if (deb_cnt_q == 32'(DEB_CYC - 1)) begin
                    key_db_d = key_s;
                end else begin
                    deb_cnt_d = deb_cnt_q + 32'd1;
                end
            end
        end

        // Events are decoded from the debouncer's next value so they align with the key_db edge.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            first_d    = 1'b0;
            short_d    = 1'b0;
            long_d     = long_q;
`ifdef KEY_REPEAT_EN
            rep_cnt_d  = rep_cnt_q;
`endif
            case (state_q)
                IDLE: begin
                    long_d = 1'b0;
                    if (key_db_d && !key_db_q) begin
                        state_d    = HELD;
                        first_d    = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                HELD: begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                    if (!key_db_d) begin
                        state_d    = IDLE;
                        short_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == 32'(LONG_CYC - 1)) begin
                        state_d = LONG;
                        long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_cnt_d = '0;
`endif
                    end
                end
                LONG: begin
`ifdef KEY_REPEAT_EN
                    if (rep_cnt_q == 32'(REPEAT_CYC - 1)) begin
                        first_d   = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 32'd1;
                    end
`endif
                    if (!key_db_d) begin
                        state_d    = IDLE;
                        long_d     = 1'b0;
                        hold_cnt_d = '0;
`ifdef KEY_REPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    long_d  = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                key_db_q   <= 1'b0;
                deb_cnt_q  <= '0;
                state_q    <= IDLE;
                hold_cnt_q <= '0;
                first_q    <= 1'b0;
                short_q    <= 1'b0;
                long_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
                rep_cnt_q  <= '0;
`endif
            end else begin
                key_db_q   <= key_db_d;
                deb_cnt_q  <= deb_cnt_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                first_q    <= first_d;
                short_q    <= short_d;
                long_q     <= long_d;
`ifdef KEY_REPEAT_EN
                rep_cnt_q  <= rep_cnt_d;
`endif
            end
        end

        assign key_first[k] = first_q;
        assign key_short[k] = short_q;
        assign key_long[k]  = long_q;
        assign key_state[k] = key_db_q;
    end

endmodule

// File: tb/tb_m_key_press.sv
// Bench for m_key_press: directed scenarios plus random key activity against an elapsed-time reference model.
module tb_m_key_press;

    localparam int unsigned DEB  = 20;
    localparam int unsigned LNG  = 500;
    localparam int unsigned REP  = 100;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_in = 2'b11;
    logic [1:0] key_first, key_long, key_short, key_state;

    int n_checks = 0;
    int n_fail   = 0;

    m_key_press #(
        .N_KEYS(2), .IN_CLK_HZ(10_000), .DEBOUNCE_MS(2), .LONG_MS(50),
        .REPEAT_MS(10), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_first(key_first), .key_long(key_long),
        .key_short(key_short), .key_state(key_state)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DEB pressed-samples seen
    // through the 2-cycle synchronizer all disagree with the current level;
    // press classification is derived from elapsed edges since the accepted press.
    logic [1:0]  m_first = '0, m_short = '0, m_long = '0, m_db = '0;
    logic [1:0]  hist [0:20];
    int unsigned press_t [2];
    int unsigned cyc = 0;

    initial begin
        for (int i = 0; i <= 20; i++) hist[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_first = '0; m_short = '0; m_long = '0; m_db = '0; cyc = 0;
                for (int i = 0; i <= 20; i++) hist[i] = '0;
            end else begin
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    logic        all_new;
                    logic        prev;
                    int unsigned el;
                    all_new = 1'b1;
                    for (int i = 1; i <= int'(DEB); i++)
                        if (hist[i][k] == m_db[k]) all_new = 1'b0;
                    prev = m_db[k];
                    m_first[k] = 1'b0;
                    m_short[k] = 1'b0;
                    if (all_new) m_db[k] = ~m_db[k];
                    if (m_db[k] && !prev) begin
                        m_first[k] = 1'b1;
                        press_t[k] = cyc;
                    end else if (prev) begin
                        el = cyc - press_t[k];
`ifdef KEY_REPEAT_EN
                        if (el > LNG && (el - LNG) % REP == 0) m_first[k] = 1'b1;
`endif
                        if (!m_db[k]) begin
                            if (el <= LNG) m_short[k] = 1'b1;
                            m_long[k] = 1'b0;
                        end else begin
                            m_long[k] = (el >= LNG);
                        end
                    end
                end
                for (int i = 20; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = ~key_in;
            end
        end
    end

    task automatic test_reset();
        int nz = 0;
        rst_n  = 1'b0;
        key_in = 2'b11;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({key_first, key_long, key_short, key_state} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000", {key_first, key_long, key_short, key_state});
        end
        rst_n = 1'b1;
        for (int j = 1; j <= 1000; j++) begin
            @(negedge clk);
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL reset_idle_model edge %0d: got %b expected %b", j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            if ({key_first, key_long, key_short, key_state} !== 8'h00) nz++;
        end
        n_checks++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL reset_idle_zero: got %0d nonzero cycles expected 0", nz);
        end
    endtask

    task automatic test_bounce();
        int n_first0 = 0, n_first1 = 0, e_first = -1;
        for (int i = 0; i < 12; i++) begin
            key_in[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) begin
                @(negedge clk);
                n_checks++;
                if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                    n_fail++;
                    $display("FAIL bounce_model: got %b expected %b",
                             {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
                end
                n_first0 += int'(key_first[0]);
                n_first1 += int'(key_first[1]);
            end
        end
        key_in[0] = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (j == 60) key_in[0] = 1'b1;
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL bounce_model edge %0d: got %b expected %b", j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            if (key_first[0]) e_first = j;
            n_first0 += int'(key_first[0]);
            n_first1 += int'(key_first[1]);
        end
        n_checks++;
        if (n_first0 != 1) begin n_fail++; $display("FAIL bounce_count: got %0d key_first[0] pulses expected 1", n_first0); end
        n_checks++;
        if (e_first != 22) begin n_fail++; $display("FAIL bounce_edge: got edge %0d expected 22", e_first); end
        n_checks++;
        if (n_first1 != 0) begin n_fail++; $display("FAIL bounce_other_key: got %0d pulses expected 0", n_first1); end
    endtask

    task automatic test_short_press(input int hold, input int e_short_exp, input int e_long_exp);
        int e_first = -1, e_short = -1, e_long = -1, n_short = 0, n_long = 0;
        key_in[0] = 1'b0;
        for (int j = 1; j <= hold + 60; j++) begin
            @(negedge clk);
            if (j == hold) key_in[0] = 1'b1;
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL press_%0d_model edge %0d: got %b expected %b", hold, j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            if (key_first[0] && e_first < 0) e_first = j;
            if (key_short[0]) begin n_short++; e_short = j; end
            if (key_long[0]) begin n_long++; if (e_long < 0) e_long = j; end
        end
        n_checks++;
        if (e_first != 22) begin n_fail++; $display("FAIL press_%0d_first: got edge %0d expected 22", hold, e_first); end
        n_checks++;
        if (e_short != e_short_exp || n_short > 1) begin
            n_fail++;
            $display("FAIL press_%0d_short: got edge %0d (%0d pulses) expected %0d", hold, e_short, n_short, e_short_exp);
        end
        n_checks++;
        if (e_long != e_long_exp || (e_long_exp >= 0 && n_long != 1)) begin
            n_fail++;
            $display("FAIL press_%0d_long: got first edge %0d (%0d cycles) expected %0d", hold, e_long, n_long, e_long_exp);
        end
    endtask

    task automatic test_long();
        int e_first [$];
        int e_rise = -1, e_fall = -1, n_short = 0;
        logic long_prev = 1'b0;
`ifdef KEY_REPEAT_EN
        int exp_first [6] = '{22, 622, 722, 822, 922, 1022};
`else
        int exp_first [1] = '{22};
`endif
        key_in[1] = 1'b0;
        for (int j = 1; j <= 1100; j++) begin
            @(negedge clk);
            if (j == 1000) key_in[1] = 1'b1;
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL long_model edge %0d: got %b expected %b", j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            if (key_first[1]) e_first.push_back(j);
            if (key_long[1] && !long_prev) e_rise = j;
            if (!key_long[1] && long_prev) e_fall = j;
            long_prev = key_long[1];
            n_short += int'(key_short[1]);
        end
        n_checks++;
        if (e_rise != 522) begin n_fail++; $display("FAIL long_rise: got edge %0d expected 522", e_rise); end
        n_checks++;
        if (e_fall != 1022) begin n_fail++; $display("FAIL long_fall: got edge %0d expected 1022", e_fall); end
        n_checks++;
        if (n_short != 0) begin n_fail++; $display("FAIL long_no_short: got %0d pulses expected 0", n_short); end
        n_checks++;
        if (e_first.size() != $size(exp_first)) begin
            n_fail++;
            $display("FAIL long_first_count: got %0d pulses expected %0d", e_first.size(), $size(exp_first));
        end else begin
            for (int i = 0; i < $size(exp_first); i++) begin
                n_checks++;
                if (e_first[i] != exp_first[i]) begin
                    n_fail++;
                    $display("FAIL long_first_edge[%0d]: got %0d expected %0d", i, e_first[i], exp_first[i]);
                end
            end
        end
    endtask

    task automatic test_simul_reset();
        int e_both = -1, e_both2 = -1;
        key_in = 2'b00;
        for (int j = 1; j <= 322; j++) begin
            @(negedge clk);
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL simul_model edge %0d: got %b expected %b", j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            if (key_first == 2'b11 && e_both < 0) e_both = j;
        end
        n_checks++;
        if (e_both != 22) begin n_fail++; $display("FAIL simul_first: got edge %0d expected 22", e_both); end
        n_checks++;
        if (key_state !== 2'b11) begin n_fail++; $display("FAIL simul_state_before_reset: got %b expected 11", key_state); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({key_first, key_long, key_short, key_state} !== 8'h00) begin
            n_fail++;
            $display("FAIL simul_async_reset: got %b expected 00000000", {key_first, key_long, key_short, key_state});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 30) key_in = 2'b11;
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL simul_after_reset edge %0d: got %b expected %b", j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            if (key_first == 2'b11 && e_both2 < 0) e_both2 = j;
        end
        n_checks++;
        if (e_both2 != 22) begin n_fail++; $display("FAIL simul_repress: got edge %0d expected 22", e_both2); end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random();
        int remain [2] = '{10, 17};
        for (int j = 0; j < 8000; j++) begin
            @(negedge clk);
            n_checks++;
            if ({key_first, key_long, key_short, key_state} !== {m_first, m_long, m_short, m_db}) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %b expected %b", j,
                         {key_first, key_long, key_short, key_state}, {m_first, m_long, m_short, m_db});
            end
            for (int k = 0; k < 2; k++) begin
                remain[k]--;
                if (remain[k] <= 0) begin
                    key_in[k] = ~key_in[k];
                    if (key_in[k] == 1'b1) remain[k] = int'($urandom_range(3, 60));
                    else case ($urandom_range(0, 3))
                        0: remain[k] = int'($urandom_range(3, 30));
                        1: remain[k] = int'($urandom_range(40, 400));
                        2: remain[k] = int'($urandom_range(495, 505));
                        default: remain[k] = int'($urandom_range(600, 900));
                    endcase
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_press(200, 222, -1);
        test_short_press(500, 522, -1);
        test_short_press(501, -1, 522);
        test_long();
        test_simul_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
